program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
// Boot-time loader upstream of the 8-bit processor's instruction memory.
// - Receives a framed byte stream over a valid/ready interface.
// - Writes the payload into instruction memory starting at address 0.
// - Verifies an 8-bit checksum, then releases the processor via cpu_run.
// - The processor's program counter and control are held while cpu_run=0.
// PARAMETERS
// ADDR_W   5     instruction-memory address width; DEPTH = 2**ADDR_W words of 8 bits
// TIMEOUT  1000  max idle cycles between accepted bytes mid-frame; 0 disables timeout
// PORTS
// clock       in   1       rising-edge system clock
// reset       in   1       asynchronous, active-high; returns block to IDLE
// rx_data     in   8       incoming byte
// rx_valid    in   1       rx_data valid
// rx_ready    out  1       loader can accept; byte taken on edge with rx_valid&&rx_ready
// start       in   1       re-arm pulse; honoured only in DONE or ERR
// imem_we     out  1       instruction-memory write strobe, one cycle per payload byte
// imem_addr   out  ADDR_W  write address
// imem_wdata  out  8       write data
// cpu_run     out  1       1 = program loaded and verified, processor may execute
// busy        out  1       1 in LEN/DATA/CHK
// done        out  1       1 in DONE
// error       out  1       1 in ERR
// BEHAVIOUR
// Frame format: SYNC(0xA5), LEN, LEN payload bytes, CHK.
// - CHK = sum of payload bytes mod 256.
// - LEN valid range 1..min(DEPTH,255).
// States: IDLE, LEN, DATA, CHK, DONE, ERR. Reset -> IDLE.
// Reset values:
// - imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, busy=0, done=0, error=0.
// - rx_ready=1, decoded from IDLE.
// rx_ready=1 in IDLE/LEN/DATA/CHK; 0 in DONE/ERR.
// State transitions (all on an accepted byte unless noted):
// - IDLE: 0xA5 -> LEN; any other byte is discarded, state unchanged.
// - LEN: valid LEN -> DATA; store LEN, clear byte counter and checksum.
// - LEN: LEN=0 or LEN>min(DEPTH,255) -> ERR.
// - DATA: each byte k (0-based) -> next cycle imem_we=1, imem_addr=k, imem_wdata=byte.
// - DATA: checksum += byte (8-bit wrap).
// - DATA: after byte LEN-1 -> CHK.
// - CHK: byte == checksum -> DONE; otherwise -> ERR.
// - DONE: cpu_run=1 from the first cycle in DONE. start=1 -> IDLE, cpu_run drops next cycle.
// - ERR: start=1 -> IDLE.
// Write path:
// - Write latency is exactly 1 cycle after acceptance; imem_we is never high for 2 cycles per byte.
// - Back-to-back accepted bytes give back-to-back writes.
// - imem_addr/imem_wdata hold their last value when imem_we=0.
// Timeout, when TIMEOUT>0:
// - Idle counter clears on every accepted byte and on entry to LEN.
// - Counts every cycle in LEN/DATA/CHK without an accepted byte.
// - Reaching TIMEOUT -> ERR. The counter does not run in IDLE, DONE or ERR.
// Simultaneous events:
// - start in IDLE/LEN/DATA/CHK is ignored.
// - In DONE/ERR, rx_valid is ignored (rx_ready=0).
// - A timeout and an accepted byte in the same cycle: the byte wins and the counter clears.
// Reset mid-operation:
// - Immediate return to IDLE, all outputs to reset values, cpu_run=0.
// - Already-written memory words are not cleared.
// TESTING
// 1. reset; send A5,03,11,22,33,66 -> writes (0,11),(1,22),(2,33); done=1, cpu_run=1 after CHK.
// 2. send A5,02,10,20,31 (bad CHK, expected 30) -> error=1, cpu_run=0; start pulse -> IDLE, rx_ready=1.
// 3. send A5,00 and, separately, A5,21 (33>DEPTH) -> error=1, imem_we never asserted.
// 4. send 00,FF,5A then A5,01,07,07 -> garbage ignored, one write (0,07), done=1.
// 5. TIMEOUT=1000: send A5,02,01 then idle 1000 cycles -> error=1 on cycle 1000; no 2nd write.
// 6. assert reset after 2 of 4 payload bytes -> cpu_run=0, IDLE; full reload succeeds, done=1.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream boot loader for the instruction memory
//
// Purpose: accepts SYNC(0xA5), LEN, LEN payload bytes, CHK over a valid/ready
// byte stream. It writes the payload to instruction memory from address 0,
// checks CHK against the 8-bit sum of the payload, and releases the processor
// through cpu_run_o once the program is verified.
//
// Ports:
//   clock_i       rising-edge clock
//   reset_i       asynchronous active-high reset, returns to IDLE
//   rx_data_i     incoming byte
//   rx_valid_i    rx_data_i valid
//   rx_ready_o    byte accepted on an edge with rx_valid_i && rx_ready_o
//   start_i       re-arm pulse, honoured only in DONE or ERR
//   imem_we_o     one-cycle write strobe per payload byte
//   imem_addr_o   write address (holds when imem_we_o=0)
//   imem_wdata_o  write data (holds when imem_we_o=0)
//   cpu_run_o     program loaded and verified
//   busy_o        receiving LEN/DATA/CHK
//   done_o        in DONE
//   error_o       in ERR
module program_loader #(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 1000
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic              start_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [7:0]        imem_wdata_o,
  output logic              cpu_run_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int MAX_LEN = (DEPTH < 255) ? DEPTH : 255;
  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen on the last idle cycle before the timeout fires.
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [7:0]    SYNC    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic accept;
  logic in_frame;
  logic len_bad;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      idle_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      idle_q  <= idle_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    idle_d  = idle_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    in_frame   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
    rx_ready_o = (state_q == S_IDLE) || in_frame;
    accept     = rx_valid_i && rx_ready_o;
    len_bad    = (rx_data_i == 8'd0) || (32'(rx_data_i) > MAX_LEN);

    unique case (state_q)
      S_IDLE: begin
        if (accept && rx_data_i == SYNC) begin
          state_d = S_LEN;
          idle_d  = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (len_bad) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
            len_d   = rx_data_i;
            cnt_d   = '0;
            csum_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = ADDR_W'(cnt_q);
          wdata_d = rx_data_i;
          csum_d  = csum_q + rx_data_i;
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) state_d = (rx_data_i == csum_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        if (start_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Idle watchdog: an accepted byte always wins over an expiring count.
    if (TIMEOUT > 0 && in_frame) begin
      if (accept) begin
        idle_d = '0;
      end else if (idle_q == TO_LAST) begin
        state_d = S_ERR;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_run_o    = (state_q == S_DONE);
  assign done_o       = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERR);
  assign busy_o       = in_frame;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              cpu_run, busy, done, error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [12:0] wq[$];
  logic [7:0]  payload[$];

  program_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock_i(clk), .reset_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready), .start_i(start), .imem_we_o(imem_we),
    .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata), .cpu_run_o(cpu_run),
    .busy_o(busy), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) wq.push_back({imem_addr, imem_wdata});

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_for_byte", rx_ready, 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic b,
                              input logic r);
    check_eq({tag, "_done"}, done, d);
    check_eq({tag, "_error"}, error, e);
    check_eq({tag, "_cpu_run"}, cpu_run, d);
    check_eq({tag, "_busy"}, busy, b);
    check_eq({tag, "_rx_ready"}, rx_ready, r);
  endtask

  // Writes expected for the current payload (k, payload[k]) when exp_writes is set.
  task automatic check_writes(input string tag, input bit exp_writes);
    int exp_n = exp_writes ? payload.size() : 0;
    check_eq({tag, "_wr_count"}, wq.size(), exp_n);
    for (int k = 0; k < exp_n && k < wq.size(); k++)
      check_eq({tag, "_wr"}, wq[k], {ADDR_W'(k), payload[k]});
  endtask

  // Sends a full frame; the checksum byte is the payload sum plus chk_err.
  task automatic send_frame(input logic [7:0] chk_err, input int max_gap);
    logic [7:0] sum = 8'd0;
    send_byte(8'hA5);
    send_byte(8'(payload.size()));
    foreach (payload[k]) begin
      sum += payload[k];
      send_byte(payload[k]);
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
    end
    send_byte(sum + chk_err);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rearm();
    pulse_start();
    #1 check_status("rearm", 0, 0, 0, 1);
    wq.delete();
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_status("reset", 0, 0, 0, 1);
    check_eq("reset_we", imem_we, 0);
    check_eq("reset_addr", imem_addr, 0);
    check_eq("reset_wdata", imem_wdata, 0);
    @(negedge clk) rst = 1'b0;

    // Known good frame A5,03,11,22,33,66.
    payload = '{8'h11, 8'h22, 8'h33};
    wq.delete();
    send_frame(8'd0, 0);
    check_writes("basic", 1);
    check_status("basic", 1, 0, 0, 0);
    // rx_valid while DONE must be ignored.
    @(negedge clk) rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rx_valid = 1'b0;
    check_eq("done_ignores_rx_wr", wq.size(), 3);
    check_status("done_hold", 1, 0, 0, 0);
    rearm();

    // Bad checksum A5,02,10,20,31.
    payload = '{8'h10, 8'h20};
    send_frame(8'd1, 0);
    check_writes("badchk", 1);
    check_status("badchk", 0, 1, 0, 0);
    rearm();

    // Bad lengths 0 and DEPTH+1.
    send_byte(8'hA5); send_byte(8'h00);
    #1 check_status("len0", 0, 1, 0, 0);
    check_eq("len0_wr", wq.size(), 0);
    rearm();
    send_byte(8'hA5); send_byte(8'(DEPTH + 1));
    #1 check_status("len33", 0, 1, 0, 0);
    check_eq("len33_wr", wq.size(), 0);
    rearm();

    // Garbage before sync, then A5,01,07,07; start during DATA is ignored.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_byte(8'hA5); send_byte(8'h01);
    pulse_start();
    #1 check_eq("start_ignored_busy", busy, 1);
    send_byte(8'h07); send_byte(8'h07);
    repeat (2) @(posedge clk);
    #1;
    payload = '{8'h07};
    check_writes("garbage", 1);
    check_status("garbage", 1, 0, 0, 0);
    rearm();

    // Timeout: A5,02,01 then idle.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
    repeat (999) @(posedge clk);
    #1 check_eq("timeout_early", error, 0);
    @(posedge clk);
    #1 check_eq("timeout_fire", error, 1);
    payload = '{8'h01};
    check_writes("timeout", 1);
    rearm();

    // Reset after 2 of 4 payload bytes, then full reload.
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'hC1); send_byte(8'hC2);
    @(negedge clk) rst = 1'b1;
    #1;
    check_status("midreset", 0, 0, 0, 1);
    check_eq("midreset_we", imem_we, 0);
    check_eq("midreset_addr", imem_addr, 0);
    check_eq("midreset_wdata", imem_wdata, 0);
    payload = '{8'hC1, 8'hC2};
    check_writes("midreset", 1);
    @(negedge clk) rst = 1'b0;
    wq.delete();
    payload = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_frame(8'd0, 1);
    check_writes("reload", 1);
    check_status("reload", 1, 0, 0, 0);
    rearm();

    // Randomized frames: good, bad checksum, bad length, with leading garbage.
    for (int f = 0; f < 30; f++) begin
      int kind = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g);
      end
      if (kind == 2) begin
        logic [7:0] bl = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(DEPTH + 1, 255));
        send_byte(8'hA5);
        send_byte(bl);
        #1 check_status("rnd_badlen", 0, 1, 0, 0);
        check_eq("rnd_badlen_wr", wq.size(), 0);
      end else begin
        payload.delete();
        repeat ($urandom_range(1, DEPTH)) payload.push_back(8'($urandom));
        send_frame((kind == 0) ? 8'd0 : 8'($urandom_range(1, 255)), 2);
        check_writes("rnd", 1);
        check_status("rnd", kind == 0, kind == 1, 0, 0);
      end
      rearm();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
